gate_self_test: RTL and testbench

Self-test sequencer for 2-input combinational gates on the board. It drives all four input vectors into a gate under test and samples the gate's output after a settle window. It compares each sample against a parameterised truth table and latches a pass/fail result. Its LED status outputs feed the board `Led` drivers directly, so a gate can be checked on hardware without a host.

---
 rtl/gate_self_test_if.sv | 14 +
 rtl/gate_self_test.sv | 100 ++++++++++
 tb/tb_gate_self_test.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gate_self_test_if.sv
// gate_self_test_if: run request, gate-under-test pins and status/LED outputs of the self-test sequencer
interface gate_self_test_if;
  logic start;
  logic gate_a;
  logic gate_b;
  logic gate_y;
  logic done;
  logic pass;
  logic [3:0] fail_mask;
  logic led2;
  logic led3;
  modport master(input start, gate_y, output gate_a, gate_b, done, pass, fail_mask, led2, led3);
  modport slave(output start, gate_y, input gate_a, gate_b, done, pass, fail_mask, led2, led3);
endinterface

// File: rtl/gate_self_test.sv
// gate_self_test: drives all four vectors into a 2-input gate, samples after a settle window, latches pass/fail
module gate_self_test #(
  parameter logic [3:0] EXPECTED = 4'b1110,
  parameter int SETTLE_CYCLES = 4,
  parameter int BLINK_BITS = 24
) (
  input logic clk,
  input logic rst_n,
  gate_self_test_if.master bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [BLINK_BITS-1:0] BLINK_ONE = 1;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d, ab_q, ab_d;
  logic [7:0] settle_q, settle_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [3:0] fail_q, fail_d;
  logic start_q, start_rise;
  logic done_q, done_d, pass_q, pass_d, led2_q, led2_d, led3_q, led3_d;
  always_comb begin
    start_rise = bus.start & ~start_q;
    state_d = state_q;
    idx_d = idx_q;
    ab_d = ab_q;
    settle_d = settle_q;
    fail_d = fail_q;
    done_d = done_q;
    pass_d = pass_q;
    blink_d = blink_q + BLINK_ONE;
    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d = DRIVE;
          idx_d = 2'd0;
          ab_d = 2'd0;
          settle_d = 8'd0;
          fail_d = 4'd0;
          done_d = 1'b0;
          pass_d = 1'b0;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) state_d = SAMPLE;
        else settle_d = settle_q + 8'd1;
      end
      SAMPLE: begin
        if (bus.gate_y != EXPECTED[idx_q]) fail_d[idx_q] = 1'b1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
          done_d = 1'b1;
          pass_d = (fail_d == 4'd0);
        end else begin
          state_d = DRIVE;
          idx_d = idx_q + 2'd1;
          ab_d = idx_q + 2'd1;
          settle_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    // LEDs are registered from next-state values so they line up with the state they describe
    led2_d = (state_d == DRIVE || state_d == SAMPLE) ? blink_d[BLINK_BITS-1] : (state_d == DONE) & pass_d;
    led3_d = (state_d == DONE) & ~pass_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= 2'd0;
      ab_q <= 2'd0;
      settle_q <= 8'd0;
      blink_q <= '0;
      fail_q <= 4'd0;
      start_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      led2_q <= 1'b0;
      led3_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ab_q <= ab_d;
      settle_q <= settle_d;
      blink_q <= blink_d;
      fail_q <= fail_d;
      start_q <= bus.start;
      done_q <= done_d;
      pass_q <= pass_d;
      led2_q <= led2_d;
      led3_q <= led3_d;
    end
  end
  assign bus.gate_a = ab_q[1];
  assign bus.gate_b = ab_q[0];
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.fail_mask = fail_q;
  assign bus.led2 = led2_q;
  assign bus.led3 = led3_q;
endmodule

// File: tb/tb_gate_self_test.sv
// tb_gate_self_test: directed runs of the gate self-test against modelled good and faulty gates
module tb_gate_self_test;
  localparam logic [3:0] EXP = 4'b1110;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int mode = 0;
  time t0 = 0;
  typedef struct {
    string tag;
    logic pass;
    logic [3:0] mask;
    logic led2;
    logic led3;
  } exp_t;
  exp_t sb[$];
  gate_self_test_if bus();
  gate_self_test #(.EXPECTED(EXP), .SETTLE_CYCLES(4), .BLINK_BITS(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // modes: 0 ideal OR, 1 stuck-at-0, 2 AND, 3 OR that is wrong outside the SAMPLE cycle
  function automatic logic model_y(input int m, input logic a, input logic b);
    return m == 1 ? 1'b0 : m == 2 ? (a & b) : (a | b);
  endfunction
  always @(negedge clk)
    bus.gate_y = model_y(mode, bus.gate_a, bus.gate_b) ^ (mode == 3 && ((($time - t0) / 10) % 5) != 4);
  function automatic exp_t model(input string tag, input int m);
    exp_t e;
    e.tag = tag;
    e.mask = 4'd0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      e.mask[i] = model_y(m, v[1], v[0]) != EXP[i];
    end
    e.pass = (e.mask == 4'd0);
    e.led2 = e.pass;
    e.led3 = !e.pass;
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start_edge(input logic hold);
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk) t0 = $time;
    @(negedge clk) bus.start = hold;
    chk("start_done_clr", {31'd0, bus.done}, 0);
    chk("start_mask_clr", {28'd0, bus.fail_mask}, 0);
  endtask
  task automatic finish_run(input int n0);
    int n;
    exp_t e;
    n = n0;
    while (bus.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk({e.tag, "_latency"}, n, 20);
    chk({e.tag, "_pass"}, {31'd0, bus.pass}, {31'd0, e.pass});
    chk({e.tag, "_mask"}, {28'd0, bus.fail_mask}, {28'd0, e.mask});
    chk({e.tag, "_led2"}, {31'd0, bus.led2}, {31'd0, e.led2});
    chk({e.tag, "_led3"}, {31'd0, bus.led3}, {31'd0, e.led3});
  endtask
  task automatic outputs_zero(input string tag);
    chk(tag, {22'd0, bus.gate_a, bus.gate_b, bus.done, bus.pass, bus.fail_mask, bus.led2, bus.led3}, 0);
  endtask
  task automatic idle_check(input string tag);
    logic on;
    on = 1'b0;
    repeat (8) @(negedge clk) on |= bus.led2 | bus.done | bus.gate_a | bus.gate_b;
    chk(tag, {31'd0, on}, 0);
  endtask
  initial begin
    logic l2 [20];
    logic stay;
    int errs;
    bus.start = 1'b0;
    bus.gate_y = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) outputs_zero("reset_state");
    rst_n = 1'b1;
    idle_check("idle_quiet");
    mode = 0;
    sb.push_back(model("ideal_or", 0));
    start_edge(1'b0);
    finish_run(0);
    mode = 1;
    sb.push_back(model("stuck0", 1));
    start_edge(1'b0);
    repeat (10) @(negedge clk);
    chk("stuck0_mid_mask", {28'd0, bus.fail_mask}, 32'b0010);
    finish_run(10);
    mode = 2;
    sb.push_back(model("and_gate", 2));
    start_edge(1'b0);
    finish_run(0);
    mode = 3;
    sb.push_back(model("glitch", 3));
    start_edge(1'b0);
    finish_run(0);
    mode = 1;
    start_edge(1'b0);
    repeat (12) @(negedge clk);
    chk("abort_mid_mask", {28'd0, bus.fail_mask}, 32'b0010);
    rst_n = 1'b0;
    @(negedge clk) outputs_zero("abort_reset");
    rst_n = 1'b1;
    idle_check("abort_idle");
    mode = 0;
    sb.push_back(model("after_abort", 0));
    start_edge(1'b0);
    finish_run(0);
    sb.push_back(model("held_start", 0));
    start_edge(1'b1);
    l2[0] = bus.led2;
    for (int n = 1; n < 20; n++) @(negedge clk) l2[n] = bus.led2;
    errs = 0;
    for (int n = 4; n < 20; n++) if (l2[n] !== ~l2[n-4]) errs++;
    chk("blink_period", errs, 0);
    finish_run(19);
    stay = 1'b1;
    repeat (30) @(negedge clk) stay &= bus.done & bus.led2;
    chk("held_no_rerun", {31'd0, stay}, 1);
    @(negedge clk) bus.start = 1'b0;
    sb.push_back(model("restart", 0));
    start_edge(1'b0);
    finish_run(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
